uart_tx: RTL
============

# uart_tx

UART transmit serializer, the TX stage of the `uart` top. It sits beside `uart_rx` and downstream of `uart_clk_gen`, consuming its `uart_ce` bit-rate strobe. It accepts bytes over a valid/ready handshake and drives the `ms_utx` pad line. The frame format is start bit, 7 or 8 data bits, optional parity, then 1 or 2 stop bits.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; single clock domain
- `rstb`  in  1  asynchronous active-low reset
- `uart_ce`  in  1  one-`clk` pulse per bit period, from `uart_clk_gen`
- `cfg_enable`  in  1  transmitter enable
- `cfg_has_parity`  in  1  append parity bit
- `cfg_odd_parity`  in  1  1 = odd parity, 0 = even parity
- `cfg_extend_stop`  in  1  1 = two stop bits, 0 = one stop bit
- `cfg_lsb_first`  in  1  1 = bit 0 sent first, 0 = MSB of the word sent first
- `cfg_word`  in  1  1 = 8 data bits `[7:0]`; 0 = 7 data bits `[6:0]`
- `uart_tx_data`  in  8  byte to send
- `uart_tx_valid`  in  1  `uart_tx_data` is valid
- `uart_tx_ready`  out  1  block can accept a byte this cycle
- `uart_tx_busy`  out  1  a frame is in progress (state ≠ IDLE)
- `uart_tx_empty_it`  out  1  one-cycle pulse when the transmitter becomes fully idle
- `ms_utx`  out  1  serial output; idle high

## Operation
- **Transfer rule:** a transfer occurs on a `clk` edge with `uart_tx_valid & uart_tx_ready`.
  - The data word and all `cfg_*` inputs except `cfg_enable` are snapshotted at that edge.
  - Config changes mid-frame do not affect the current frame.
- **States:** IDLE → START → DATA → [PARITY] → STOP1 → [STOP2] → IDLE, or → START if another byte is pending.
  - All transitions occur only on edges where `uart_ce=1`.
  - IDLE→START occurs on the first `uart_ce` edge after a byte is pending.
  - DATA uses a 3-bit counter; it leaves DATA after 8 bits (`cfg_word=1`) or 7 bits (`cfg_word=0`).
- **Line value per state (registered):**
  - START: `ms_utx=0`.
  - DATA: the current shift bit, in LSB-first or MSB-first order. With 7-bit words, MSB-first starts at bit 6.
  - PARITY: XOR of the transmitted data bits, XORed with `cfg_odd_parity`.
  - STOP and IDLE: `ms_utx=1`.
- **Ready:** `uart_tx_ready = cfg_enable & (state==IDLE) & ~pending`.
- **Empty interrupt:** `uart_tx_empty_it` pulses on the `uart_ce` edge that leaves the final stop bit with nothing pending.
- **`cfg_enable` deasserted at any time:**
  - The FSM returns to IDLE on the next `clk` edge.
  - `ms_utx=1`, any pending byte is discarded, and no `uart_tx_empty_it` pulse is generated.
- **Reset values:**
  - State IDLE, no byte pending.
  - `ms_utx=1`, `uart_tx_busy=0`, `uart_tx_empty_it=0`.
  - `uart_tx_ready` follows its equation, so it reads 1 if `cfg_enable=1`.

## Timing
- Every bit lasts exactly one `uart_ce` interval.
  - `ms_utx` changes on the `clk` edge where `uart_ce=1` and is stable otherwise.
- **Start latency:** from the accept edge to the start bit on the line, between 1 `clk` cycle and one bit period. The start bit begins at the first `uart_ce` edge strictly after acceptance.
- **Frame length:** 1 + (7|8) + (0|1) + (1|2) bit periods.
- **Accept on a `uart_ce` cycle:** if acceptance and `uart_ce` fall on the same edge, the start bit begins at the next `uart_ce`, not the current one.
- `uart_tx_empty_it` is exactly one `clk` cycle wide and coincident with the line entering IDLE.
- **Reset mid-frame:** asynchronous; `ms_utx` goes high immediately and the frame is truncated.

## Configuration
- **Macro:** `UART_TX_HOLD_EN`.
- **Defined:** adds a one-byte holding register with its own config snapshot.
  - `uart_tx_ready = cfg_enable & ~hold_full`.
  - A byte may be accepted while a frame is shifting.
  - At the last stop-bit `uart_ce` edge, the held byte moves to START directly, with no idle bit between frames.
  - `uart_tx_empty_it` fires only when both the shifter and the holding register are empty.
  - Disable or reset flushes the holding register.
- **Undefined:** no holding register.
  - Ready only in IDLE; frames are separated by at least the IDLE→START wait.
  - Behaviour is exactly as in Operation.

## Test plan
- **8N1, LSB-first, `0xA5`:**
  - Line sequence: 0, then 1,0,1,0,0,1,0,1, then 1.
  - 10 `uart_ce` periods total, then one `uart_tx_empty_it` pulse.
- **8-bit, even parity, 2 stop bits, MSB-first, `0xA5`:**
  - Line sequence: 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1,1.
  - Repeating with odd parity gives parity bit 1.
- **7-bit, LSB-first, no parity, `0xFF`:**
  - 7 data bits of 1, then 1 stop bit.
  - Bit 7 is ignored; the frame is 9 periods.
- **`cfg_enable` dropped mid-DATA:**
  - Next cycle: `ms_utx=1`, `uart_tx_busy=0`, no `uart_tx_empty_it` pulse.
  - After re-enable, `0x3C` transmits correctly.
- **Back-to-back `0x55` then `0xAA` with `uart_tx_valid` held high:**
  - `UART_TX_HOLD_EN` defined: the second start bit immediately follows the first stop bit, and a single `uart_tx_empty_it` pulse occurs at the end.
  - `UART_TX_HOLD_EN` undefined: at least one idle-high period between frames.
- **`rstb` asserted mid-frame:**
  - Immediately: `ms_utx=1`, state IDLE.
  - The first frame after release is correct.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmit serializer. Frame: start, 7/8 data, optional parity,
//            1/2 stop. Macro UART_TX_HOLD_EN adds a one-byte holding register
//            so back-to-back frames leave no idle bit between them.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx (
  input  logic       clk,
  input  logic       rstb,
  input  logic       uart_ce,
  input  logic       cfg_enable,
  input  logic       cfg_has_parity,
  input  logic       cfg_odd_parity,
  input  logic       cfg_extend_stop,
  input  logic       cfg_lsb_first,
  input  logic       cfg_word,
  input  logic [7:0] uart_tx_data,
  input  logic       uart_tx_valid,
  output logic       uart_tx_ready,
  output logic       uart_tx_busy,
  output logic       uart_tx_empty_it,
  output logic       ms_utx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_e;

  typedef struct packed {
    logic has_parity;
    logic odd_parity;
    logic extend_stop;
    logic lsb_first;
    logic word8;
  } cfg_t;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       line_q, line_d;
  logic       empty_q, empty_d;
  logic [7:0] act_data_q;
  cfg_t       act_cfg_q;
  cfg_t       cfg_in;
  logic       accept;
  logic       load;
  logic       frame_end;
  logic [2:0] last_idx;
  logic [2:0] bit_idx;
  logic       parity_bit;

  assign cfg_in = {cfg_has_parity, cfg_odd_parity, cfg_extend_stop,
                   cfg_lsb_first, cfg_word};
  assign accept = uart_tx_valid & uart_tx_ready;

`ifdef UART_TX_HOLD_EN
  logic [7:0] hold_data_q;
  cfg_t       hold_cfg_q;

  assign uart_tx_ready = cfg_enable & ~pend_q;

  // Holding register is filled on accept and drained into the shifter at START.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hold_data_q <= '0;
      hold_cfg_q  <= '0;
      act_data_q  <= '0;
      act_cfg_q   <= '0;
    end else begin
      if (accept) begin
        hold_data_q <= uart_tx_data;
        hold_cfg_q  <= cfg_in;
      end
      if (load) begin
        act_data_q <= hold_data_q;
        act_cfg_q  <= hold_cfg_q;
      end
    end
  end
`else
  assign uart_tx_ready = cfg_enable & (state_q == S_IDLE) & ~pend_q;

  // Accept only happens in IDLE, so the shifter snapshot can be taken directly.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      act_data_q <= '0;
      act_cfg_q  <= '0;
    end else if (accept) begin
      act_data_q <= uart_tx_data;
      act_cfg_q  <= cfg_in;
    end
  end
`endif

  assign last_idx   = act_cfg_q.word8 ? 3'd7 : 3'd6;
  assign parity_bit = (act_cfg_q.word8 ? ^act_data_q : ^act_data_q[6:0])
                      ^ act_cfg_q.odd_parity;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    empty_d   = 1'b0;
    load      = 1'b0;
    frame_end = 1'b0;
    if (accept) begin
      pend_d = 1'b1;
    end
    if (!cfg_enable) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end else if (uart_ce) begin
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            state_d = S_START;
            load    = 1'b1;
          end
        end
        S_START: begin
          state_d = S_DATA;
          cnt_d   = 3'd0;
        end
        S_DATA: begin
          if (cnt_q == last_idx) begin
            state_d = act_cfg_q.has_parity ? S_PARITY : S_STOP1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_PARITY: state_d = S_STOP1;
        S_STOP1: begin
          if (act_cfg_q.extend_stop) begin
            state_d = S_STOP2;
          end else begin
            frame_end = 1'b1;
          end
        end
        S_STOP2: frame_end = 1'b1;
        default: state_d = S_IDLE;
      endcase
      // A queued byte chains straight into START without an idle bit.
      if (frame_end) begin
        if (pend_q) begin
          state_d = S_START;
          load    = 1'b1;
        end else begin
          state_d = S_IDLE;
          empty_d = 1'b1;
        end
      end
    end
    if (load) begin
      pend_d = 1'b0;
    end
  end

  assign bit_idx = act_cfg_q.lsb_first ? cnt_d : (last_idx - cnt_d);

  // Line is a function of the next state so it updates on the same edge.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = act_data_q[bit_idx];
      S_PARITY: line_d = parity_bit;
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
      line_q  <= 1'b1;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      line_q  <= line_d;
      empty_q <= empty_d;
    end
  end

  assign ms_utx           = line_q;
  assign uart_tx_busy     = (state_q != S_IDLE);
  assign uart_tx_empty_it = empty_q;

endmodule
`default_nettype wire
